// File: rtl/tfc_sensor_cond_pkg.sv
// Shared definitions for the traffic-light controller sensor front end:
// lamp and stretch-state encodings, default timing, and a counter-width helper.
package tfc_sensor_cond_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESENT = 2'b01,
        HOLD    = 2'b10
    } stretch_e;

    localparam int unsigned DEF_DB_CYCLES   = 4;
    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_CNT_W       = 8;

    // Width of a down/up counter spanning 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tfc_sensor_cond_chan.sv
// One detector channel: 2-flop synchroniser, stability debounce, presence
// stretch FSM and, with TFC_VEH_COUNT_EN, a saturating vehicle counter.
module tfc_sensor_cond_chan
    import tfc_sensor_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             det,
    input  logic             cnt_clr,
    output logic             t,
    output logic [CNT_W-1:0] cnt
);

    localparam int unsigned DB_W   = cnt_width(DB_CYCLES);
    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    logic            s1;
    logic            s2;
    logic            st;
    logic [DB_W-1:0] db_cnt;

    stretch_e          state_q;
    stretch_e          state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              t_d;
    logic              veh_inc;

    // Synchroniser and debounce: st flips only after DB_CYCLES disagreeing samples
    always_ff @(posedge CLK) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            st     <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= det;
            s2 <= s1;
            if (s2 != st) begin
                if (db_cnt == DB_LAST) begin
                    st     <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Stretch FSM next state; HOLD bridges short gaps between vehicles
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (st) state_d = PRESENT;
            end
            PRESENT: begin
                if (!st) begin
                    if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (st) begin
                    state_d = PRESENT;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign t_d     = (state_d != IDLE);
    assign veh_inc = (state_q == IDLE) && (state_d == PRESENT);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            t       <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            t       <= t_d;
        end
    end

`ifdef TFC_VEH_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear beats a same-cycle increment; HOLD->PRESENT is the same platoon
    always_ff @(posedge CLK) begin
        if (reset || cnt_clr) begin
            cnt <= '0;
        end else if (veh_inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt;

    assign cnt        = '0;
    assign unused_cnt = cnt_clr ^ veh_inc;
`endif

endmodule

// File: rtl/tfc_sensor_cond.sv
// Conditions the street A/B loop detectors into the T_A/T_B presence flags.
// Define TFC_VEH_COUNT_EN to enable the per-street saturating vehicle counters.
module tfc_sensor_cond
    import tfc_sensor_cond_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             det_a,
    input  logic             det_b,
    input  logic             cnt_clr,
    output logic             T_A,
    output logic             T_B,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    tfc_sensor_cond_chan #(
        .DB_CYCLES  (DB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_a (
        .CLK    (CLK),
        .reset  (reset),
        .det    (det_a),
        .cnt_clr(cnt_clr),
        .t      (T_A),
        .cnt    (cnt_a)
    );

    tfc_sensor_cond_chan #(
        .DB_CYCLES  (DB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_chan_b (
        .CLK    (CLK),
        .reset  (reset),
        .det    (det_b),
        .cnt_clr(cnt_clr),
        .t      (T_B),
        .cnt    (cnt_b)
    );

endmodule

// File: tb/tb_tfc_sensor_cond.sv
// Directed bench for tfc_sensor_cond at DB_CYCLES=4, HOLD_CYCLES=8, CNT_W=8.
module tb_tfc_sensor_cond;

    localparam int unsigned CNT_W = 8;
`ifdef TFC_VEH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             reset;
    logic             det_a;
    logic             det_b;
    logic             cnt_clr;
    logic             T_A;
    logic             T_B;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    tfc_sensor_cond #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(8),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .det_a  (det_a),
        .det_b  (det_b),
        .cnt_clr(cnt_clr),
        .T_A    (T_A),
        .T_B    (T_B),
        .cnt_a  (cnt_a),
        .cnt_b  (cnt_b)
    );

    always #5 CLK = ~CLK;

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Index of the first posedge (0 = first edge after the call) after which T == want; -1 on timeout
    task automatic wait_t(input bit chan_b, input logic want, input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if ((chan_b ? T_B : T_A) === want) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1; det_a = 1'b1; det_b = 1'b1; cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_total++;
            if ({T_A, T_B} !== 2'b00 || cnt_a !== '0 || cnt_b !== '0)
                $display("FAIL reset_hold cyc%0d: T_A=%b T_B=%b cnt_a=%0d cnt_b=%0d want all 0",
                         i, T_A, T_B, cnt_a, cnt_b);
            else n_pass++;
        end
        reset = 1'b0;
        wait_t(1'b0, 1'b1, 20, lat);
        n_total++;
        if (lat !== 6) $display("FAIL reset_release_lat: got %0d want 6", lat);
        else n_pass++;
        n_total++;
        if (T_B !== 1'b1) $display("FAIL reset_release_tb: got %b want 1", T_B);
        else n_pass++;
        det_a = 1'b0; det_b = 1'b0;
        apply_reset();
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        det_a = 1'b1;
        cycles(3);
        det_a = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (T_A !== 1'b0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL glitch_ta: T_A asserted on 3-cycle pulse, want never");
        else n_pass++;
        n_total++;
        if (cnt_a !== '0) $display("FAIL glitch_cnt: got %0d want 0", cnt_a);
        else n_pass++;
    endtask

    task automatic test_rise();
        int lat;
        det_a = 1'b1;
        wait_t(1'b0, 1'b1, 20, lat);
        n_total++;
        if (lat !== 6) $display("FAIL rise_lat: got %0d want 6", lat);
        else n_pass++;
        n_total++;
        if (T_B !== 1'b0) $display("FAIL rise_tb_indep: got %b want 0", T_B);
        else n_pass++;
        n_total++;
        if (cnt_a !== CNT_W'(CNT_ON)) $display("FAIL rise_cnt: got %0d want %0d", cnt_a, CNT_ON);
        else n_pass++;
    endtask

    task automatic test_stretch();
        int  lat;
        bit  dropped = 1'b0;
        det_a = 1'b0;
        wait_t(1'b0, 1'b0, 30, lat);
        n_total++;
        if (lat !== 14) $display("FAIL fall_lat: got %0d want 14", lat);
        else n_pass++;
        det_a = 1'b1;
        wait_t(1'b0, 1'b1, 20, lat);
        n_total++;
        if (lat !== 6) $display("FAIL rerise_lat: got %0d want 6", lat);
        else n_pass++;
        cycles(3);
        det_a = 1'b0;
        cycles(5);
        det_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (T_A !== 1'b1) dropped = 1'b1;
        end
        n_total++;
        if (dropped) $display("FAIL gap_bridge: T_A dropped during 5-cycle gap, want held at 1");
        else n_pass++;
        n_total++;
        if (cnt_a !== CNT_W'(2 * CNT_ON)) $display("FAIL gap_cnt: got %0d want %0d", cnt_a, 2 * CNT_ON);
        else n_pass++;
    endtask

    task automatic test_hold_reset();
        bit rose = 1'b0;
        det_a = 1'b0;
        cycles(11);
        n_total++;
        if (T_A !== 1'b1) $display("FAIL hold_pre: got %b want 1", T_A);
        else n_pass++;
        reset = 1'b1;
        @(negedge CLK);
        n_total++;
        if (T_A !== 1'b0 || cnt_a !== '0) $display("FAIL hold_reset: T_A=%b cnt_a=%0d want 0/0", T_A, cnt_a);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (T_A !== 1'b0) rose = 1'b1;
        end
        n_total++;
        if (rose) $display("FAIL hold_residual: T_A reasserted after reset, want 0");
        else n_pass++;
    endtask

    task automatic test_count();
        for (int p = 0; p < 300; p++) begin
            det_b = 1'b1;
            cycles(10);
            det_b = 1'b0;
            cycles(20);
            if (p == 9) begin
                n_total++;
                if (cnt_b !== CNT_W'(10 * CNT_ON)) $display("FAIL cnt_10: got %0d want %0d", cnt_b, 10 * CNT_ON);
                else n_pass++;
            end
        end
        n_total++;
        if (cnt_b !== CNT_W'(255 * CNT_ON)) $display("FAIL cnt_sat: got %0d want %0d", cnt_b, 255 * CNT_ON);
        else n_pass++;
        n_total++;
        if (T_A !== 1'b0 || cnt_a !== '0) $display("FAIL cnt_a_indep: T_A=%b cnt_a=%0d want 0/0", T_A, cnt_a);
        else n_pass++;
        cycles(20);
        det_b = 1'b1;
        cycles(6);
        n_total++;
        if (T_B !== 1'b0) $display("FAIL clr_pre: T_B got %b want 0", T_B);
        else n_pass++;
        cnt_clr = 1'b1;
        @(negedge CLK);
        cnt_clr = 1'b0;
        n_total++;
        if (T_B !== 1'b1 || cnt_b !== '0) $display("FAIL clr_vs_inc: T_B=%b cnt_b=%0d want 1/0", T_B, cnt_b);
        else n_pass++;
        det_b = 1'b0;
        cycles(40);
        det_b = 1'b1;
        cycles(10);
        n_total++;
        if (cnt_b !== CNT_W'(CNT_ON)) $display("FAIL cnt_after_clr: got %0d want %0d", cnt_b, CNT_ON);
        else n_pass++;
        det_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_rise();
        test_stretch();
        test_hold_reset();
        test_count();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
